// File: rtl/dmem_arbiter_if.sv
// Bundle of requester-side and dmem-side signals around the shared data-memory port.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface dmem_arbiter_if #(
   parameter int AW = 7,
   parameter int DW = 32
);
   logic          req0;
   logic          req1;
   logic          we0;
   logic          we1;
   logic [3:0]    amp0;
   logic [3:0]    amp1;
   logic [AW-1:0] addr0;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata0;
   logic [DW-1:0] wdata1;
   logic          ack0;
   logic          ack1;
   logic [DW-1:0] rdata;
   logic          stall0;
   logic          ram_we;
   logic [3:0]    ram_amp;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wd;
   logic [DW-1:0] ram_rd;

   modport slave (
      input  req0, req1, we0, we1, amp0, amp1, addr0, addr1, wdata0, wdata1, ram_rd,
      output ack0, ack1, rdata, stall0, ram_we, ram_amp, ram_addr, ram_wd
   );

   modport master (
      output req0, req1, we0, we1, amp0, amp1, addr0, addr1, wdata0, wdata1, ram_rd,
      input  ack0, ack1, rdata, stall0, ram_we, ram_amp, ram_addr, ram_wd
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of the single dmem port.
// IDLE -> GRANT (dmem access) -> DONE (ack); DONE chains straight into GRANT for the other port.
module dmem_arbiter #(
   parameter int AW = 7,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_last;
   logic          r_owner;
   logic          r_we;
   logic [3:0]    r_amp;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wd;
   logic [DW-1:0] r_rdata;
   logic          r_ack0;
   logic          r_ack1;
   logic          r_ram_we;

   logic          w_load;
   logic          w_port;
   logic          w_we;
   logic [3:0]    w_amp;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wd;

   // Pick the next port to latch; in DONE only the non-owner may be chained.
   always_comb begin
      w_load = 1'b0;
      w_port = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.req0 && bus.req1) begin
               w_load = 1'b1;
               w_port = ~r_last;
            end else if (bus.req0) begin
               w_load = 1'b1;
               w_port = 1'b0;
            end else if (bus.req1) begin
               w_load = 1'b1;
               w_port = 1'b1;
            end else begin
               w_load = 1'b0;
               w_port = 1'b0;
            end
         end
         ST_DONE: begin
            w_port = ~r_owner;
            w_load = r_owner ? bus.req0 : bus.req1;
         end
         default: begin
            w_load = 1'b0;
            w_port = 1'b0;
         end
      endcase
   end

   // Payload of the selected port.
   always_comb begin
      w_we   = 1'b0;
      w_amp  = 4'd0;
      w_addr = {AW{1'b0}};
      w_wd   = {DW{1'b0}};
      if (w_port) begin
         w_we   = bus.we1;
         w_amp  = bus.amp1;
         w_addr = bus.addr1;
         w_wd   = bus.wdata1;
      end else begin
         w_we   = bus.we0;
         w_amp  = bus.amp0;
         w_addr = bus.addr0;
         w_wd   = bus.wdata0;
      end
   end

   // FSM with access registers, read-data capture and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_last   <= 1'b1;
         r_owner  <= 1'b0;
         r_we     <= 1'b0;
         r_amp    <= 4'd0;
         r_addr   <= {AW{1'b0}};
         r_wd     <= {DW{1'b0}};
         r_rdata  <= {DW{1'b0}};
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_ram_we <= 1'b0;
      end else begin
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_ram_we <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_load) begin
                  r_state  <= ST_GRANT;
                  r_owner  <= w_port;
                  r_we     <= w_we;
                  r_amp    <= w_amp;
                  r_addr   <= w_addr;
                  r_wd     <= w_wd;
                  r_ram_we <= w_we;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               // dmem read is combinational, so the word is ready to capture here.
               if (!r_we) begin
                  r_rdata <= bus.ram_rd;
               end else begin
                  r_rdata <= r_rdata;
               end
               r_last  <= r_owner;
               r_ack0  <= ~r_owner;
               r_ack1  <= r_owner;
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ack0     = r_ack0;
   assign bus.ack1     = r_ack1;
   assign bus.rdata    = r_rdata;
   assign bus.stall0   = bus.req0 & ~r_ack0;
   assign bus.ram_we   = r_ram_we;
   assign bus.ram_amp  = r_amp;
   assign bus.ram_addr = r_addr;
   assign bus.ram_wd   = r_wd;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random single accesses,
// checked against a word-level memory model and the fixed IDLE/GRANT/DONE timing.
module tb_dmem_arbiter;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   dmem_arbiter_if #(.AW(7), .DW(32)) bus ();

   dmem_arbiter #(.AW(7), .DW(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Memory behind the arbiter, with a backdoor used only for preloading.
   logic [31:0] mem [0:127];
   int          wr_count;
   logic        bd_we;
   logic [6:0]  bd_addr;
   logic [31:0] bd_data;

   initial wr_count = 0;

   always @(posedge clk) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (bus.ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.ram_amp[b]) mem[bus.ram_addr][8*b +: 8] <= bus.ram_wd[8*b +: 8];
         end
         wr_count <= wr_count + 1;
      end
   end

   assign bus.ram_rd = mem[bus.ram_addr];

   logic [31:0] ref_mem [0:127];
   logic [31:0] exp_rdata;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] amp);
      logic [31:0] m;
      m = 32'h0;
      for (int b = 0; b < 4; b++) begin
         if (amp[b]) m = m | (32'hFF << (8 * b));
      end
      return (old & ~m) | (wd & m);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [6:0] a, input logic [31:0] v);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_data = v;
      ref_mem[a] = v;
      step();
      bd_we = 1'b0;
   endtask

   task automatic drive(input bit port, input bit req, input bit we, input logic [3:0] amp,
                        input logic [6:0] addr, input logic [31:0] wd);
      if (port) begin
         bus.req1 = req; bus.we1 = we; bus.amp1 = amp; bus.addr1 = addr; bus.wdata1 = wd;
      end else begin
         bus.req0 = req; bus.we0 = we; bus.amp0 = amp; bus.addr0 = addr; bus.wdata0 = wd;
      end
   endtask

   // One access from IDLE: request, GRANT next cycle, ack in the cycle after, then IDLE.
   task automatic do_access(input bit port, input bit we, input logic [3:0] amp,
                            input logic [6:0] addr, input logic [31:0] wd, input bit drop_early);
      int w0;
      w0 = wr_count;
      drive(port, 1'b1, we, amp, addr, wd);
      #1;
      chk("req_stall0", 32'(bus.stall0), 32'(port == 1'b0));
      chk("req_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      chk("req_ram_we", 32'(bus.ram_we), 32'd0);
      step();
      chk("gr_ram_we", 32'(bus.ram_we), 32'(we));
      chk("gr_ram_addr", 32'(bus.ram_addr), 32'(addr));
      chk("gr_ram_amp", 32'(bus.ram_amp), 32'(amp));
      chk("gr_ram_wd", bus.ram_wd, wd);
      chk("gr_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      chk("gr_stall0", 32'(bus.stall0), 32'(port == 1'b0));
      drive(port, !drop_early, $urandom_range(0, 1), 4'($urandom), 7'($urandom), $urandom);
      step();
      chk("dn_ack0", 32'(bus.ack0), 32'(port == 1'b0));
      chk("dn_ack1", 32'(bus.ack1), 32'(port == 1'b1));
      chk("dn_stall0", 32'(bus.stall0), 32'd0);
      chk("dn_ram_we", 32'(bus.ram_we), 32'd0);
      if (we) ref_mem[addr] = merge(ref_mem[addr], wd, amp);
      else exp_rdata = ref_mem[addr];
      chk("dn_rdata", bus.rdata, exp_rdata);
      drive(port, 1'b0, 1'b0, 4'd0, 7'd0, 32'd0);
      step();
      chk("id_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      chk("id_ram_we", 32'(bus.ram_we), 32'd0);
      chk("id_rdata", bus.rdata, exp_rdata);
      chk("wr_count", 32'(wr_count - w0), 32'(we));
   endtask

   initial begin
      logic [31:0] v;
      logic [6:0]  a0;
      logic [6:0]  a1;
      int          p;
      clk = 1'b0; rst = 1'b1; total = 0; bad = 0; exp_rdata = 32'd0;
      bd_we = 1'b0; bd_addr = 7'd0; bd_data = 32'd0;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 7'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 32'd0);
      for (int i = 0; i < 128; i++) begin
         v = $urandom;
         poke(7'(i), v);
      end
      poke(7'd5, 32'h12345678);
      poke(7'd20, 32'h11223344);

      // Reset state; stall0 follows req0 directly.
      chk("rst_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("rst_ram_amp", 32'(bus.ram_amp), 32'd0);
      chk("rst_ram_wd", bus.ram_wd, 32'd0);
      bus.req0 = 1'b1;
      #1;
      chk("rst_stall0_hi", 32'(bus.stall0), 32'd1);
      bus.req0 = 1'b0;
      #1;
      chk("rst_stall0_lo", 32'(bus.stall0), 32'd0);
      rst = 1'b0;
      step();

      do_access(1'b0, 1'b0, 4'hF, 7'd5, $urandom, 1'b0);
      chk("p0_read5", bus.rdata, 32'h12345678);

      do_access(1'b1, 1'b1, 4'hF, 7'd9, 32'hCAFEF00D, 1'b0);
      do_access(1'b0, 1'b0, 4'hF, 7'd9, 32'd0, 1'b0);
      chk("p1w_p0r", bus.rdata, 32'hCAFEF00D);

      do_access(1'b0, 1'b1, 4'b0010, 7'd20, 32'h0000AB00, 1'b0);
      do_access(1'b1, 1'b0, 4'hF, 7'd20, 32'd0, 1'b0);
      chk("byte_write", bus.rdata, 32'h1122AB44);

      do_access(1'b1, 1'b1, 4'hF, 7'd33, $urandom, 1'b1);
      step();
      chk("drop_no_rewrite", 32'(bus.ram_we), 32'd0);

      for (int k = 0; k < 24; k++) begin
         do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
                   7'($urandom), $urandom, $urandom_range(0, 3) == 0);
      end

      // Reset during GRANT of a read: nothing completes, re-request succeeds.
      drive(1'b0, 1'b1, 1'b0, 4'hF, 7'd40, 32'd0);
      step();
      chk("mid_gr_addr", 32'(bus.ram_addr), 32'd40);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_rdata = 32'd0;
      chk("mid_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
      chk("mid_rdata", bus.rdata, 32'd0);
      chk("mid_ram_addr", 32'(bus.ram_addr), 32'd0);
      chk("mid_ram_amp", 32'(bus.ram_amp), 32'd0);
      chk("mid_ram_we", 32'(bus.ram_we), 32'd0);
      do_access(1'b0, 1'b0, 4'hF, 7'd40, 32'd0, 1'b0);

      // Both ports held from reset: acks alternate 0,1,0,1 every other cycle.
      a0 = 7'd50;
      a1 = 7'd51;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 4'hF, a0, $urandom);
      drive(1'b1, 1'b1, 1'b0, 4'hF, a1, $urandom);
      step();
      rst = 1'b0;
      exp_rdata = 32'd0;
      chk("fair_rst_rdata", bus.rdata, 32'd0);
      chk("fair_stall0", 32'(bus.stall0), 32'd1);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c % 2 == 1) begin
            p = ((c - 1) / 2) % 2;
            chk("fair_gr_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
            chk("fair_gr_addr", 32'(bus.ram_addr), 32'((p == 1) ? a1 : a0));
         end else begin
            p = ((c / 2) - 1) % 2;
            chk("fair_ack0", 32'(bus.ack0), 32'(p == 0));
            chk("fair_ack1", 32'(bus.ack1), 32'(p == 1));
            exp_rdata = ref_mem[(p == 1) ? a1 : a0];
            chk("fair_rdata", bus.rdata, exp_rdata);
         end
         chk("fair_ram_we", 32'(bus.ram_we), 32'd0);
      end
      drive(1'b0, 1'b0, 1'b0, 4'd0, 7'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 7'd0, 32'd0);
      step();
      chk("fair_end_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and sequencer that shares the single data-memory port (`dmem`: synchronous write, combinational read, 7-bit word address, 4-bit byte-lane mask) between the CPU data path (port 0, via `MIO_BUS` RAM-side signals) and a second bus master (port 1: loader/debug/DMA engine). It sits between the requesters and `dmem` on the `Clk_CPU` domain. It serialises accesses with a req/ack handshake and registers read data. It also produces a stall indication so the CPU can hold its memory stage while the other port is served.

## Interface
- `AW`, default 7: word-address width (matches `dmem` `a`).
- `DW`, default 32: data width.
- `clk` in 1: CPU clock (`Clk_CPU`); all logic on rising edge.
- `rst` in 1: synchronous reset, active-high.
- `req0`, `req1` in 1: access request; held with payload until matching ack.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `amp0`, `amp1` in 4: byte-lane mask passed to `dmem` `amp`.
- `addr0`, `addr1` in AW: word address.
- `wdata0`, `wdata1` in DW: write data.
- `ack0`, `ack1` out 1: one-cycle pulse; the access has completed.
- `rdata` out DW: registered read data, valid in the ack cycle, held until the next read completes.
- `stall0` out 1: `req0 & ~ack0`; CPU memory-stage hold.
- `ram_we` out 1: drives `dmem` `we`.
- `ram_amp` out 4: drives `dmem` `amp`.
- `ram_addr` out AW: drives `dmem` `a`.
- `ram_wd` out DW: drives `dmem` `wd`.
- `ram_rd` in DW: from `dmem` `rd` (combinational).

## Operation
- FSM states are IDLE, GRANT and DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: latch that port's `we/amp/addr/wdata` into the access registers, set `owner`, go to GRANT.
  - Both requesting: the winner is the port ≠ `last`. `last` resets to 1, so port 0 wins the first tie.
- GRANT (exactly one cycle):
  - `ram_addr/ram_amp/ram_wd` come from the access registers. `ram_we` = latched `we`.
  - On the clock edge: for a read, `rdata <= ram_rd`; `last <= owner`; go to DONE.
- DONE (exactly one cycle):
  - `ack[owner]` = 1.
  - The owner's `req` is still high this cycle and is ignored.
  - If the other port requests: latch its payload, set `owner`, go directly to GRANT (no IDLE bubble). Otherwise go to IDLE.
- `ram_we` = 1 only in GRANT with latched `we` = 1. In all other states `ram_we` = 0, and `ram_addr/ram_amp/ram_wd` hold their last latched values.
- A write does not update `rdata`.
- Payload changes after latching are ignored. The access completes with the values latched at grant.
- A requester that drops `req` after being latched still receives its ack pulse.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1. Neither port waits more than one foreign access.

## Timing
- Reset: state = IDLE, `last` = 1, `owner` = 0, access registers = 0, `rdata` = 0, `ack0` = `ack1` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_amp` = 0, `ram_wd` = 0. `stall0` = `req0`.
- Latency from IDLE: `req` seen at edge n. GRANT in cycle n+1. Ack and valid `rdata` in cycle n+2.
- Back-to-back on alternating ports: one access every 2 cycles (GRANT, DONE).
- Same port back-to-back: DONE → IDLE → GRANT, i.e. one access every 3 cycles.
- Reset asserted mid-GRANT: the write already issued in that cycle completes in `dmem`. From the next cycle everything is at reset values, no ack is issued, and the requester must re-request.
- `ack*` are registered-state decodes (functions of state and `owner` only), free of combinational paths from `req*`. `stall0` is the only combinational req-to-output path.

## Test plan
- Port 0 read only: `dmem[5]` = 0x12345678, `req0`/`addr0`=5/`we0`=0 at cycle 0 → `ram_we` stays 0; `ack0` is high in cycle 2 only; `rdata` = 0x12345678 in cycle 2; `stall0` is high in cycles 0-1.
- Port 1 write then port 0 read of the same address: `we1`=1, `addr1`=9, `wdata1`=0xCAFEF00D, `amp1`=4'hF → `ram_we` is high for exactly one cycle; a following port-0 read of 9 returns 0xCAFEF00D.
- Simultaneous `req0`/`req1` out of reset, held continuously → ack order 0,1,0,1,…, with `ack1` 2 cycles after `ack0`, and no gap cycles.
- Byte write: `amp0`=4'b0010, `wdata0`=0x0000AB00 to a word holding 0x11223344 → a read-back returns 0x1122AB44.
- Reset pulsed in GRANT of a read → no ack; the state is IDLE with all outputs at reset values; a re-issued request completes normally 2 cycles later.
- `req1` dropped one cycle after latching → `ack1` still pulses once; no second access to that address is issued.
